// File: rtl/stack_pkg.sv
// Shared op-codes, sequencer state encoding and the micro-step tables that
// expand each stack-machine op into its ordered push/pop accesses.
package stack_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_DUP   = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_ADD   = 3'd5;
  localparam logic [2:0] OP_SUB   = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CLR   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [2:0] STEP_NONE   = 3'd0;
  localparam logic [2:0] STEP_PUSH_D = 3'd1;
  localparam logic [2:0] STEP_PUSH_A = 3'd2;
  localparam logic [2:0] STEP_PUSH_B = 3'd3;
  localparam logic [2:0] STEP_PUSH_R = 3'd4;
  localparam logic [2:0] STEP_POP_A  = 3'd5;
  localparam logic [2:0] STEP_POP_B  = 3'd6;

  function automatic logic [2:0] seq_step(input logic [2:0] op, input logic [1:0] idx);
    logic [2:0] s;
    s = STEP_NONE;
    case (op)
      OP_PUSH: s = STEP_PUSH_D;
      OP_POP:  s = STEP_POP_A;
      OP_DUP:  s = (idx == 2'd0) ? STEP_POP_A : STEP_PUSH_A;
      OP_SWAP: begin
        case (idx)
          2'd0:    s = STEP_POP_A;
          2'd1:    s = STEP_POP_B;
          2'd2:    s = STEP_PUSH_A;
          default: s = STEP_PUSH_B;
        endcase
      end
      OP_ADD, OP_SUB: begin
        case (idx)
          2'd0:    s = STEP_POP_A;
          2'd1:    s = STEP_POP_B;
          default: s = STEP_PUSH_R;
        endcase
      end
      default: s = STEP_NONE;
    endcase
    return s;
  endfunction

  // Index of the final access in the op's sequence.
  function automatic logic [1:0] seq_last(input logic [2:0] op);
    logic [1:0] l;
    case (op)
      OP_DUP, OP_ADD, OP_SUB: l = 2'd2;
      OP_SWAP:                l = 2'd3;
      default:                l = 2'd0;
    endcase
    return l;
  endfunction

  function automatic logic step_is_push(input logic [2:0] s);
    return (s == STEP_PUSH_D) || (s == STEP_PUSH_A) || (s == STEP_PUSH_B) || (s == STEP_PUSH_R);
  endfunction

  function automatic logic step_is_pop(input logic [2:0] s);
    return (s == STEP_POP_A) || (s == STEP_POP_B);
  endfunction

endpackage

// File: rtl/stack_ptr.sv
// Stack pointer (occupancy) register: clear beats inc/dec, inc+dec together hold.
module stack_ptr #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_pointer,
  input  logic             inc_pointer,
  input  logic             dec_pointer,
  output logic [DEPTH-1:0] pointer
);

  localparam logic [DEPTH-1:0] ONE = {{(DEPTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             pointer <= '0;
    else if (rst_pointer)                 pointer <= '0;
    else if (inc_pointer && !dec_pointer) pointer <= pointer + ONE;
    else if (dec_pointer && !inc_pointer) pointer <= pointer - ONE;
  end

endmodule

// File: rtl/stack_ctrl.sv
// Sequencer for one stack instance: expands stack-machine ops into push/pop
// accesses spaced two cycles apart so each pointer update lands before the next.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_data_in,
  output logic             stk_rst,
  input  logic [WIDTH-1:0] stk_data_out,
  input  logic             stk_rst_pointer,
  input  logic             stk_inc_pointer,
  input  logic             stk_dec_pointer,
  output logic [DEPTH-1:0] pointer
);

  logic [2:0]       state_q, nstate;
  logic [1:0]       idx_q, nidx;
  logic [2:0]       op_q, op_n, step_n;
  logic [WIDTH-1:0] data_q, data_n, a_q, a_n, b_q, b_n;
  logic [WIDTH-1:0] result, push_val;
  logic             accept, ok, err_n;
  int               pv;

  stack_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk         (clk),
    .rst         (rst),
    .rst_pointer (stk_rst_pointer),
    .inc_pointer (stk_inc_pointer),
    .dec_pointer (stk_dec_pointer),
    .pointer     (pointer)
  );

  always_comb begin
    accept = cmd_valid && cmd_ready;
    pv     = 32'(pointer);
    case (cmd_op)
      OP_PUSH:                ok = (pv < DEPTH);
      OP_POP:                 ok = (pv >= 1);
      OP_DUP:                 ok = (pv >= 1) && (pv < DEPTH);
      OP_SWAP, OP_ADD, OP_SUB: ok = (pv >= 2);
      default:                ok = 1'b1;
    endcase

    nstate = state_q;
    nidx   = idx_q;
    op_n   = op_q;
    data_n = data_q;
    a_n    = a_q;
    b_n    = b_q;
    err_n  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_n   = cmd_op;
          data_n = cmd_data;
          nidx   = 2'd0;
          err_n  = !ok;
          if (!ok || cmd_op == OP_NOP) nstate = ST_DONE;
          else if (cmd_op == OP_CLEAR) nstate = ST_CLR;
          else                         nstate = ST_ISSUE;
        end
      end
      ST_ISSUE: nstate = ST_WAIT;
      ST_CLR:   nstate = ST_WAIT;
      ST_WAIT: begin
        // Popped word is captured here, so a following push can forward it.
        if (seq_step(op_q, idx_q) == STEP_POP_A) a_n = stk_data_out;
        if (seq_step(op_q, idx_q) == STEP_POP_B) b_n = stk_data_out;
        if (op_q == OP_CLEAR || idx_q == seq_last(op_q)) begin
          nstate = ST_DONE;
        end else begin
          nstate = ST_ISSUE;
          nidx   = idx_q + 2'd1;
        end
      end
      default: nstate = ST_IDLE;
    endcase

    step_n = seq_step(op_n, nidx);
    case (op_n)
      OP_ADD:         result = b_n + a_n;
      OP_SUB:         result = b_n - a_n;
      OP_POP, OP_DUP: result = a_n;
      OP_SWAP:        result = b_n;
      default:        result = '0;
    endcase
    case (step_n)
      STEP_PUSH_D: push_val = data_n;
      STEP_PUSH_A: push_val = a_n;
      STEP_PUSH_B: push_val = b_n;
      STEP_PUSH_R: push_val = result;
      default:     push_val = '0;
    endcase
  end

  // Outputs are registered from the next-state view so they are glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      op_q        <= OP_NOP;
      data_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_data    <= '0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_data_in <= '0;
      stk_rst     <= 1'b1;
    end else begin
      state_q     <= nstate;
      idx_q       <= nidx;
      op_q        <= op_n;
      data_q      <= data_n;
      a_q         <= a_n;
      b_q         <= b_n;
      cmd_ready   <= (nstate == ST_IDLE);
      rsp_valid   <= (nstate == ST_DONE);
      rsp_err     <= (nstate == ST_DONE) && err_n;
      rsp_data    <= (nstate == ST_DONE && !err_n) ? result : '0;
      stk_push    <= (nstate == ST_ISSUE) && step_is_push(step_n);
      stk_pop     <= (nstate == ST_ISSUE) && step_is_pop(step_n);
      stk_data_in <= (nstate == ST_ISSUE) ? push_val : '0;
      stk_rst     <= (nstate == ST_CLR);
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized and directed bench for stack_ctrl against a queue-based stack model.
module tb_stack_ctrl;
  import stack_pkg::*;

  typedef struct packed {
    logic [4:0] lat;
    logic       err;
    logic [7:0] data;
    logic [2:0] npush;
    logic [2:0] npop;
    logic [1:0] nrst;
    logic [3:0] ptr;
    logic [1:0] nbad;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_data;
  logic       stk_push, stk_pop, stk_rst;
  logic [7:0] stk_data_in;
  logic [7:0] dout = 8'd0;
  logic       inc_p = 1'b0, dec_p = 1'b0, rst_p = 1'b0;
  logic [3:0] pointer;
  logic [7:0] mem [16];

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] mdl [$];

  stack_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_data        (cmd_data),
    .rsp_valid       (rsp_valid),
    .rsp_err         (rsp_err),
    .rsp_data        (rsp_data),
    .stk_push        (stk_push),
    .stk_pop         (stk_pop),
    .stk_data_in     (stk_data_in),
    .stk_rst         (stk_rst),
    .stk_data_out    (dout),
    .stk_rst_pointer (rst_p),
    .stk_inc_pointer (inc_p),
    .stk_dec_pointer (dec_p),
    .pointer         (pointer)
  );

  always #5 clk = ~clk;

  // Simple stack memory responding one cycle after each access request.
  always @(posedge clk) begin
    inc_p <= stk_push;
    dec_p <= stk_pop;
    rst_p <= stk_rst;
    if (stk_push) mem[pointer] <= stk_data_in;
    if (stk_pop)  dout <= mem[pointer - 4'd1];
  end

  function automatic string fmt(input obs_t o);
    return $sformatf("lat=%0d err=%0b data=%02h push=%0d pop=%0d rst=%0d ptr=%0d bad=%0d",
                     o.lat, o.err, o.data, o.npush, o.npop, o.nrst, o.ptr, o.nbad);
  endfunction

  // Reference: stack as a queue, top at the back; latency from access count.
  task automatic model_cmd(input logic [2:0] op, input logic [7:0] d, output obs_t e);
    int n, pu, po;
    logic [7:0] a, b;
    e = '0;
    n = mdl.size();
    pu = 0;
    po = 0;
    case (op)
      OP_PUSH: if (n < 4) begin mdl.push_back(d); pu = 1; end else e.err = 1'b1;
      OP_POP:  if (n >= 1) begin e.data = mdl.pop_back(); po = 1; end else e.err = 1'b1;
      OP_DUP:  if (n >= 1 && n < 4) begin
                 a = mdl[n-1]; mdl.push_back(a); e.data = a; po = 1; pu = 2;
               end else e.err = 1'b1;
      OP_SWAP: if (n >= 2) begin
                 a = mdl.pop_back(); b = mdl.pop_back();
                 mdl.push_back(a); mdl.push_back(b); e.data = b; po = 2; pu = 2;
               end else e.err = 1'b1;
      OP_ADD, OP_SUB: if (n >= 2) begin
                 a = mdl.pop_back(); b = mdl.pop_back();
                 e.data = (op == OP_ADD) ? b + a : b - a;
                 mdl.push_back(e.data); po = 2; pu = 1;
               end else e.err = 1'b1;
      OP_CLEAR: begin mdl.delete(); e.nrst = 2'd1; end
      default: ;
    endcase
    if (e.err || op == OP_NOP) e.lat = 5'd1;
    else if (op == OP_CLEAR)   e.lat = 5'd3;
    else                       e.lat = 5'(1 + 2 * (pu + po));
    e.npush = 3'(pu);
    e.npop  = 3'(po);
    e.ptr   = 4'(mdl.size());
  endtask

  // Called at a negedge; returns at the negedge after the response cycle.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] d, output obs_t o);
    o = '0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_data  = 8'($urandom);
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (stk_push) o.npush = o.npush + 3'd1;
      if (stk_pop)  o.npop  = o.npop + 3'd1;
      if (stk_rst)  o.nrst  = o.nrst + 2'd1;
      if ((stk_push && stk_pop) || (!stk_push && stk_data_in != 8'd0)) o.nbad = o.nbad + 2'd1;
      if (rsp_valid) begin
        o.lat  = 5'(k);
        o.err  = rsp_err;
        o.data = rsp_data;
        o.ptr  = pointer;
        break;
      end
    end
    @(negedge clk);
    if (rsp_valid) o.nbad = o.nbad + 2'd1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (stk_rst !== 1'b1) $display("FAIL reset_stk_rst got %b expected 1", stk_rst); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got %b expected 0", cmd_ready); else n_pass++;
    n_checks++; if ({rsp_valid, rsp_err, stk_push, stk_pop} !== 4'b0) $display("FAIL reset_outputs got %b expected 0000", {rsp_valid, rsp_err, stk_push, stk_pop}); else n_pass++;
    n_checks++; if (pointer !== 4'd0) $display("FAIL reset_pointer got %0d expected 0", pointer); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (stk_rst !== 1'b0) $display("FAIL post_reset_stk_rst got %b expected 0", stk_rst); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL post_reset_cmd_ready got %b expected 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_push_pop();
    obs_t got, exp;
    logic [2:0] ops [5];
    logic [7:0] dat [5];
    ops = '{OP_PUSH, OP_PUSH, OP_POP, OP_POP, OP_POP};
    dat = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) begin
      model_cmd(ops[i], dat[i], exp);
      run_cmd(ops[i], dat[i], got);
      n_checks++;
      if (got !== exp) $display("FAIL push_pop[%0d] got %s expected %s", i, fmt(got), fmt(exp)); else n_pass++;
      if (i == 2) begin
        n_checks++; if (got.data !== 8'h22) $display("FAIL first_pop_data got %02h expected 22", got.data); else n_pass++;
      end
    end
  endtask

  task automatic test_arith();
    obs_t got, exp;
    logic [2:0] ops [6];
    logic [7:0] dat [6];
    ops = '{OP_PUSH, OP_PUSH, OP_ADD, OP_PUSH, OP_PUSH, OP_SUB};
    dat = '{8'hF0, 8'h20, 8'h00, 8'h05, 8'h07, 8'h00};
    for (int i = 0; i < 6; i++) begin
      model_cmd(ops[i], dat[i], exp);
      run_cmd(ops[i], dat[i], got);
      n_checks++;
      if (got !== exp) $display("FAIL arith[%0d] got %s expected %s", i, fmt(got), fmt(exp)); else n_pass++;
      if (i == 2) begin
        n_checks++; if (got.data !== 8'h10 || got.lat !== 5'd7) $display("FAIL add_wrap got %02h@%0d expected 10@7", got.data, got.lat); else n_pass++;
      end
      if (i == 5) begin
        n_checks++; if (got.data !== 8'hFE) $display("FAIL sub_borrow got %02h expected fe", got.data); else n_pass++;
      end
    end
  endtask

  task automatic test_swap_dup();
    obs_t got, exp;
    logic [2:0] ops [11];
    logic [7:0] dat [11];
    ops = '{OP_CLEAR, OP_PUSH, OP_PUSH, OP_SWAP, OP_POP, OP_POP, OP_PUSH, OP_PUSH, OP_PUSH, OP_PUSH, OP_DUP};
    dat = '{8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00};
    for (int i = 0; i < 11; i++) begin
      model_cmd(ops[i], dat[i], exp);
      run_cmd(ops[i], dat[i], got);
      n_checks++;
      if (got !== exp) $display("FAIL swap_dup[%0d] got %s expected %s", i, fmt(got), fmt(exp)); else n_pass++;
    end
    n_checks++; if (got.err !== 1'b1) $display("FAIL dup_full got err=%b expected 1", got.err); else n_pass++;
  endtask

  task automatic test_clear();
    obs_t got, exp;
    logic [2:0] ops [6];
    logic [7:0] dat [6];
    ops = '{OP_CLEAR, OP_PUSH, OP_PUSH, OP_PUSH, OP_CLEAR, OP_POP};
    dat = '{8'h00, 8'h31, 8'h32, 8'h33, 8'h00, 8'h00};
    for (int i = 0; i < 6; i++) begin
      model_cmd(ops[i], dat[i], exp);
      run_cmd(ops[i], dat[i], got);
      n_checks++;
      if (got !== exp) $display("FAIL clear[%0d] got %s expected %s", i, fmt(got), fmt(exp)); else n_pass++;
    end
  endtask

  task automatic test_random();
    obs_t got, exp;
    logic [2:0] op;
    logic [7:0] d;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op = ($urandom_range(0, 2) == 0) ? OP_PUSH : 3'($urandom_range(0, 7));
      d  = 8'($urandom);
      model_cmd(op, d, exp);
      run_cmd(op, d, got);
      n_checks++;
      if (got !== exp) $display("FAIL random[%0d] op=%0d got %s expected %s", i, op, fmt(got), fmt(exp)); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    logic saw_rsp;
    int   ready_lat;
    logic [2:0] ops [4];
    logic [7:0] dat [4];
    ops = '{OP_CLEAR, OP_PUSH, OP_PUSH, OP_PUSH};
    dat = '{8'h00, 8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 4; i++) begin
      model_cmd(ops[i], dat[i], exp);
      run_cmd(ops[i], dat[i], got);
      n_checks++;
      if (got !== exp) $display("FAIL mid_setup[%0d] got %s expected %s", i, fmt(got), fmt(exp)); else n_pass++;
    end
    saw_rsp   = 1'b0;
    ready_lat = 0;
    cmd_valid = 1'b1;
    cmd_op    = OP_SWAP;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 20 && !stk_push; k++) begin
      if (rsp_valid) saw_rsp = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (pointer !== 4'd1) $display("FAIL mid_ptr_before got %0d expected 1", pointer); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (pointer !== 4'd0) $display("FAIL mid_ptr_reset got %0d expected 0", pointer); else n_pass++;
    n_checks++; if ({stk_rst, stk_push, cmd_ready} !== 3'b100) $display("FAIL mid_outputs got %b expected 100", {stk_rst, stk_push, cmd_ready}); else n_pass++;
    repeat (3) begin @(negedge clk); if (rsp_valid) saw_rsp = 1'b1; end
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
      if (cmd_ready && ready_lat == 0) ready_lat = k;
    end
    n_checks++; if (ready_lat < 1 || ready_lat > 2) $display("FAIL mid_ready_lat got %0d expected 1..2", ready_lat); else n_pass++;
    n_checks++; if (saw_rsp !== 1'b0) $display("FAIL mid_no_rsp got %b expected 0", saw_rsp); else n_pass++;
    mdl.delete();
    model_cmd(OP_POP, 8'h00, exp);
    run_cmd(OP_POP, 8'h00, got);
    n_checks++; if (got !== exp) $display("FAIL mid_pop_after got %s expected %s", fmt(got), fmt(exp)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_arith();
    test_swap_dup();
    test_clear();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Command sequencer for the `stack` block: owns the stack pointer register, issues push/pop pulses, and spaces them so each pointer update lands before the next access.
- Expands composite stack-machine ops (DUP, SWAP, ADD, SUB, CLEAR) into push/pop sequences.
- Sits between the instruction decoder (valid/ready command port) and one `stack` instance.

Parameters:
- WIDTH, 8, data word width in bits; must equal the stack's WIDTH.
- DEPTH, 4, stack capacity in entries; pointer is DEPTH bits wide, matching the stack's pointer port.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; the command is accepted on the clk edge where cmd_valid && cmd_ready.
- cmd_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 ADD, 6 SUB, 7 CLEAR.
- cmd_data  in  WIDTH  push operand; sampled at accept.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  qualified by rsp_valid; 1 = over/underflow, no stack access made.
- rsp_data  out  WIDTH  qualified by rsp_valid.
- stk_push, stk_pop  out  1  to stack push/pop; registered, never both high.
- stk_data_in  out  WIDTH  to stack data_in.
- stk_rst  out  1  active-high reset to the stack; registered.
- stk_data_out  in  WIDTH  from stack data_out.
- stk_rst_pointer, stk_inc_pointer, stk_dec_pointer  in  1  pointer-update pulses from the stack.
- pointer  out  DEPTH  stack pointer (= occupancy), fed to the stack's pointer input.

Behaviour:
- Reset (rst low, asynchronous):
  - State returns to IDLE and pointer clears to 0.
  - stk_rst=1.
  - All other outputs are 0, except cmd_ready, which is 0 during reset.
- First cycle after rst deasserts: stk_rst=0, then cmd_ready=1.
- Reset mid-operation aborts the operation silently: no rsp_valid.
- Pointer register update rules:
  - stk_rst_pointer → pointer = 0.
  - else stk_inc_pointer → pointer + 1.
  - else stk_dec_pointer → pointer - 1.
  - inc and dec together → pointer holds.
- States: IDLE, ISSUE, WAIT, CLR, DONE.
- Each stack access takes 2 cycles:
  - ISSUE drives exactly one of stk_push/stk_pop for 1 cycle.
  - WAIT captures stk_data_out (pops) and applies the inc/dec pulse; pointer is valid for the next ISSUE.
- Accept check in IDLE, using pointer p:
  - PUSH needs p<DEPTH.
  - POP needs p>=1.
  - DUP needs 1<=p<DEPTH.
  - SWAP, ADD and SUB need p>=2.
  - NOP and CLEAR always pass.
- Failed check → DONE next cycle with rsp_err=1, rsp_data=0; no stk_push/stk_pop is issued.
- Sequences (A is the first value popped, B the second):
  - PUSH: push cmd_data.
  - POP: pop A; rsp_data=A.
  - DUP: pop A, push A, push A; rsp_data=A.
  - SWAP: pop A, pop B, push A, push B; rsp_data=B (new top).
  - ADD: pop A, pop B, push (B+A) mod 2^WIDTH; rsp_data=sum.
  - SUB: pop A, pop B, push (B-A) mod 2^WIDTH; rsp_data=result.
  - No carry/borrow flag for ADD/SUB.
- CLEAR: CLR state drives stk_rst=1 for 1 cycle; pointer zeroes on the resulting stk_rst_pointer pulse; then DONE, rsp_data=0.
- NOP → DONE directly; rsp_data=0. PUSH also reports rsp_data=0.
- Latency: accept at edge 0 → rsp_valid high during cycle 1+2n, where n = number of stack accesses.
  - CLEAR → cycle 3.
  - NOP and errors → cycle 1.
- DONE lasts 1 cycle and returns to IDLE. A back-to-back command is accepted on the edge leaving IDLE.
- cmd_data, cmd_op and the internal A/B registers are held; changes on cmd_* while busy are ignored.
- stk_data_in is driven only during push ISSUE cycles, 0 otherwise.

Decomposition:
- Shared package `stack_pkg`: op-code constants (OP_NOP..OP_CLEAR), state encoding, micro-step sequence constants.
- One sub-module `stack_ptr`: pointer register with async active-low clear and rst/inc/dec priority as above.
- Sequencing FSM and step counter stay in stack_ctrl.

Test Plan (WIDTH=8, DEPTH=4):
- Reset, then PUSH 0x11, 0x22 → two stk_push pulses; pointer 1 then 2; each rsp_valid arrives 3 cycles after accept, rsp_err=0.
- POP → rsp_data=0x22 at cycle 3, pointer=1; then POP, then POP with p=0 → second POP returns 0x11; third returns rsp_err=1 at cycle 1, no stk_pop seen.
- PUSH 0xF0, PUSH 0x20, ADD → rsp_data=0x10 (wrap) at cycle 7, pointer=1, top=0x10. SUB on 0x05 then 0x07 → 0xFE.
- PUSH 1,2 then SWAP → pops return 2 then 1; POPs afterwards yield 1 then 2. Fill to 4 then DUP → rsp_err=1.
- CLEAR with p=3 → stk_rst high one cycle; pointer=0 at rsp_valid (cycle 3); then POP → rsp_err=1.
- Assert rst low during SWAP's third access → pointer=0, stk_rst=1, no rsp_valid; after release, cmd_ready=1 within 2 cycles.
